// File: rtl/bitcell_array_ctrl.sv
// bitcell_array_ctrl
//   Sequencer that owns the bitcell array interface. It accepts single-word
//   read/write requests over a valid/ready handshake. Each request walks
//   through SETUP -> STROBE -> (HOLD on writes) -> RESP. Every array-facing
//   signal and every response signal comes straight from a flop, so the
//   array never sees glitches.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we/addr/wdata     request: 1 = write, word row, write data
//   rsp_valid/rsp_rdata   one-cycle completion pulse and captured read data
//   cell_sel              one-hot row select to the array
//   cell_rw               shared read/write strobe (1 = write)
//   cell_data             shared column write data
//   cell_out              wired-OR of the column outputs of the selected row
module bitcell_array_ctrl #(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 4,
  parameter int WR_PULSE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [(2**ADDR_W)-1:0]   cell_sel,
  output logic                     cell_rw,
  output logic [DATA_W-1:0]        cell_data,
  input  logic [DATA_W-1:0]        cell_out
);

  localparam int ROWS  = 2**ADDR_W;
  // A zero-length write pulse cannot close the latch, so it is stretched to 1.
  localparam int PULSE = (WR_PULSE < 1) ? 1 : WR_PULSE;
  localparam int CNT_W = (PULSE > 1) ? $clog2(PULSE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ROWS-1:0]     cell_sel_q, cell_sel_d;
  logic                cell_rw_q, cell_rw_d;
  logic [DATA_W-1:0]   cell_data_q, cell_data_d;

  // Row decode of the latched address. STROBE is only entered from SETUP,
  // where the address has already been latched.
  logic [ROWS-1:0]     row_hit;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row_dec
      assign row_hit[gi] = (addr_q == ADDR_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_W'(PULSE - 1);
        state_d = STROBE;
      end
      STROBE: begin
        if (we_q) begin
          if (cnt_q == '0) begin
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          // Selected row is driving the columns now; capture on the exit edge.
          rsp_rdata_d = cell_out;
          state_d     = RESP;
        end
      end
      HOLD:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so every
    // output reflects the state it belongs to with no input-to-output path.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    cell_sel_d  = (state_d == STROBE) ? row_hit : '0;

    cell_rw_d   = 1'b0;
    cell_data_d = '0;
    case (state_d)
      SETUP, STROBE: begin
        cell_rw_d   = we_d;
        cell_data_d = we_d ? wdata_d : '0;
      end
      HOLD: begin
        // Keep write strobe and data stable one cycle after sel drops.
        cell_rw_d   = 1'b1;
        cell_data_d = wdata_d;
      end
      default: begin
        cell_rw_d   = 1'b0;
        cell_data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cell_sel_q  <= '0;
      cell_rw_q   <= 1'b0;
      cell_data_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cell_sel_q  <= cell_sel_d;
      cell_rw_q   <= cell_rw_d;
      cell_data_q <= cell_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign cell_sel  = cell_sel_q;
  assign cell_rw   = cell_rw_q;
  assign cell_data = cell_data_q;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Bench for bitcell_array_ctrl: one instance with WR_PULSE=1 driving a
// behavioural bitcell array, one with WR_PULSE=3 for the long-pulse case.
module tb_bitcell_array_ctrl;

  localparam int AW   = 2;
  localparam int DW   = 4;
  localparam int ROWS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A (WR_PULSE = 1)
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [ROWS-1:0] cell_sel;
  logic            cell_rw;
  logic [DW-1:0]   cell_data;
  logic [DW-1:0]   cell_out;

  // Instance B (WR_PULSE = 3)
  logic            req_valid_b = 1'b0;
  logic            req_ready_b;
  logic            req_we_b = 1'b0;
  logic [AW-1:0]   req_addr_b = '0;
  logic [DW-1:0]   req_wdata_b = '0;
  logic            rsp_valid_b;
  logic [DW-1:0]   rsp_rdata_b;
  logic [ROWS-1:0] cell_sel_b;
  logic            cell_rw_b;
  logic [DW-1:0]   cell_data_b;
  logic [DW-1:0]   cell_out_b = 4'hD;

  bitcell_array_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WR_PULSE(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cell_sel(cell_sel), .cell_rw(cell_rw), .cell_data(cell_data),
    .cell_out(cell_out)
  );

  bitcell_array_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WR_PULSE(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .cell_sel(cell_sel_b), .cell_rw(cell_rw_b), .cell_data(cell_data_b),
    .cell_out(cell_out_b)
  );

  // Behavioural bitcell array for instance A: a selected row stores the
  // column data on a clock edge while rw=1, and drives its word while rw=0.
  logic [DW-1:0] mem [ROWS];

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++)
      if (cell_sel[r] && cell_rw) mem[r] <= cell_data;
  end

  always_comb begin
    cell_out = '0;
    for (int r = 0; r < ROWS; r++)
      if (cell_sel[r] && !cell_rw) cell_out = cell_out | mem[r];
  end

  // Interface invariant monitor on instance A.
  logic [ROWS-1:0] prev_sel = '0;
  logic            prev_rw = 1'b0;
  logic [DW-1:0]   prev_data = '0;
  int              inv_err = 0;
  int              rsp_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_sel  <= '0;
      prev_rw   <= cell_rw;
      prev_data <= cell_data;
    end else begin
      if (((prev_sel != '0 || cell_sel != '0) &&
           (prev_rw !== cell_rw || prev_data !== cell_data)) ||
          ($countones(cell_sel) > 1) ||
          (cell_sel != '0 && req_ready))
        inv_err <= inv_err + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      prev_sel  <= cell_sel;
      prev_rw   <= cell_rw;
      prev_data <= cell_data;
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Wait for the request on instance A to become acceptable, then present it
  // for one accepting edge. Returns #1 after the accept edge.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int n = 0; n < 8 && !req_ready; n++) @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after an accept edge; counts cycles until rsp_valid.
  task automatic wait_rsp(output int lat, output logic [DW-1:0] rd,
                          output int selc, output logic [ROWS-1:0] selseen);
    lat = -1; rd = '0; selc = 0; selseen = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cell_sel != '0) begin
        selc++;
        selseen = selseen | cell_sel;
      end
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    int            lat;
    logic [ROWS-1:0] sel;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  int              lat, selc, c0, errb;
  logic [DW-1:0]   rd;
  logic [ROWS-1:0] selseen;

  initial begin
    // we, addr, wdata, expected rdata, expected latency, expected sel
    vec[0]  = '{1'b1, 2'd0, 4'h0, 4'h0, 4, 4'b0001};
    vec[1]  = '{1'b1, 2'd1, 4'h0, 4'h0, 4, 4'b0010};
    vec[2]  = '{1'b1, 2'd2, 4'h0, 4'h0, 4, 4'b0100};
    vec[3]  = '{1'b1, 2'd3, 4'h0, 4'h0, 4, 4'b1000};
    vec[4]  = '{1'b1, 2'd2, 4'hA, 4'h0, 4, 4'b0100};
    vec[5]  = '{1'b0, 2'd2, 4'h0, 4'hA, 3, 4'b0100};
    vec[6]  = '{1'b1, 2'd0, 4'h5, 4'hA, 4, 4'b0001};
    vec[7]  = '{1'b1, 2'd3, 4'h3, 4'hA, 4, 4'b1000};
    vec[8]  = '{1'b0, 2'd0, 4'h0, 4'h5, 3, 4'b0001};
    vec[9]  = '{1'b0, 2'd3, 4'h0, 4'h3, 3, 4'b1000};
    vec[10] = '{1'b0, 2'd1, 4'h0, 4'h0, 3, 4'b0010};
    vec[11] = '{1'b1, 2'd1, 4'hF, 4'h0, 4, 4'b0010};
    vec[12] = '{1'b0, 2'd1, 4'h0, 4'hF, 3, 4'b0010};
    vec[13] = '{1'b0, 2'd2, 4'h0, 4'hA, 3, 4'b0100};

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_sel", cell_sel, 0);
    chk("rst_rw", cell_rw, 0);
    chk("rst_data", cell_data, 0);
    chk("rst_ready_b", req_ready_b, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Table-driven transactions on instance A.
    for (int i = 0; i < NV; i++) begin
      issue(vec[i].we, vec[i].addr, vec[i].wd);
      chk($sformatf("v%0d_accept", i), req_ready, 0);
      wait_rsp(lat, rd, selc, selseen);
      $display("txn %0d: we=%0d addr=%0d wdata=%h -> lat=%0d rdata=%h sel=%b selcycles=%0d",
               i, vec[i].we, vec[i].addr, vec[i].wd, lat, rd, selseen, selc);
      chk($sformatf("v%0d_lat", i), lat, vec[i].lat);
      chk($sformatf("v%0d_rdata", i), rd, vec[i].rd);
      chk($sformatf("v%0d_sel", i), selseen, vec[i].sel);
      chk($sformatf("v%0d_selcycles", i), selc, 1);
    end

    // Busy: a write to row 1 pulsed during SETUP of a read must be ignored.
    issue(1'b0, 2'd2, 4'h0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd1; req_wdata = 4'hC;
    fork
      begin
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    join_none
    wait_rsp(lat, rd, selc, selseen);
    $display("busy read addr=2 -> lat=%0d rdata=%h sel=%b selcycles=%0d", lat, rd, selseen, selc);
    chk("busy_lat", lat, 3);
    chk("busy_rdata", rd, 4'hA);
    chk("busy_sel", selseen, 4'b0100);
    chk("busy_selcycles", selc, 1);
    @(negedge clk);
    chk("busy_ignored_ready", req_ready, 1);
    issue(1'b0, 2'd1, 4'h0);
    wait_rsp(lat, rd, selc, selseen);
    $display("busy check read addr=1 -> lat=%0d rdata=%h", lat, rd);
    chk("busy_row1_rdata", rd, 4'hF);

    // Held request: accepted in the cycle after RESP.
    for (int n = 0; n < 8 && !req_ready; n++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd0; req_wdata = 4'h0;
    @(posedge clk);
    #1 req_addr = 2'd3;
    wait_rsp(lat, rd, selc, selseen);
    $display("held first read addr=0 -> lat=%0d rdata=%h", lat, rd);
    chk("held1_lat", lat, 3);
    chk("held1_rdata", rd, 4'h5);
    @(negedge clk);
    chk("held_ready_after_resp", req_ready, 1);
    @(posedge clk);
    #1;
    chk("held_accepted", req_ready, 0);
    req_valid = 1'b0;
    wait_rsp(lat, rd, selc, selseen);
    $display("held second read addr=3 -> lat=%0d rdata=%h", lat, rd);
    chk("held2_lat", lat, 3);
    chk("held2_rdata", rd, 4'h3);

    // Reset during a write STROBE to row 1.
    issue(1'b1, 2'd1, 4'h9);
    @(negedge clk);
    @(negedge clk);
    chk("strobe_sel", cell_sel, 4'b0010);
    #1 rst = 1'b1;
    #1;
    chk("midrst_sel", cell_sel, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_rw", cell_rw, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    c0 = rsp_cnt;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    $display("reset during write strobe: responses after reset=%0d", rsp_cnt - c0);
    chk("midrst_no_rsp", rsp_cnt - c0, 0);
    issue(1'b0, 2'd2, 4'h0);
    wait_rsp(lat, rd, selc, selseen);
    $display("post-reset read addr=2 -> lat=%0d rdata=%h", lat, rd);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", rd, 4'hA);

    chk("invariants", inv_err, 0);

    // Instance B: WR_PULSE = 3.
    @(negedge clk);
    req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 2'd2; req_wdata_b = 4'h7;
    @(posedge clk);
    #1;
    chk("b_accept", req_ready_b, 0);
    req_valid_b = 1'b0;
    lat = -1; selc = 0; errb = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cell_sel_b != '0) begin
        selc++;
        if (cell_sel_b !== 4'b0100 || cell_data_b !== 4'h7 || cell_rw_b !== 1'b1) errb++;
      end
      if (rsp_valid_b) begin
        lat = c;
        break;
      end
    end
    $display("b write addr=2 wdata=7 -> lat=%0d selcycles=%0d", lat, selc);
    chk("b_wr_lat", lat, 6);
    chk("b_wr_selcycles", selc, 3);
    chk("b_wr_strobe_signals", errb, 0);
    @(negedge clk);
    req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 2'd0;
    @(posedge clk);
    #1 req_valid_b = 1'b0;
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rsp_valid_b) begin
        lat = c;
        break;
      end
    end
    $display("b read addr=0 -> lat=%0d rdata=%h", lat, rsp_rdata_b);
    chk("b_rd_lat", lat, 3);
    chk("b_rd_rdata", rsp_rdata_b, 4'hD);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
